// File: rtl/riscv_pkg.sv
// Shared encodings for the riscv_top memory subsystem: arbiter FSM states and
// the owner tag that records which requester issued the in-flight transaction.
package riscv_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction in flight, with a starvation counter that guarantees fetch progress.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e       state, state_nxt;
    logic             owner, owner_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             winner;
    logic             fetch_starved;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IF;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Starvation priority only applies while fetch is actually asking, so a
    // dropped fetch request never produces a grant nobody wants.
    assign fetch_starved = (starve_cnt >= LIMIT) && if_req;
    assign winner        = (!fetch_starved && d_req) ? OWN_D : OWN_IF;

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;
        mem_req    = 1'b0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_we     = (winner == OWN_D) ? d_we : 1'b0;
        mem_be     = (winner == OWN_D) ? d_be : '1;
        mem_addr   = (winner == OWN_D) ? d_addr : if_addr;
        mem_wdata  = d_wdata;

        unique case (state)
            ARB_IDLE: begin
                mem_req = !rst && (if_req || d_req);
                if (mem_req && mem_ready) begin
                    if_gnt    = (winner == OWN_IF);
                    d_gnt     = (winner == OWN_D);
                    owner_nxt = winner;
                    state_nxt = ARB_WAIT;
                end
                // Lost arbitrations count even while memory stalls.
                if (if_req && !if_gnt)
                    starve_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 1'b1;
                else
                    starve_nxt = '0;
            end
            ARB_WAIT: begin
                if (mem_rvalid) begin
                    if_rvalid = (owner == OWN_IF);
                    d_rvalid  = (owner == OWN_D);
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-built contention and
// reset-abandon sequences, then randomized traffic against a behavioural model.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [3:0]    d_be = 4'hf;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          rst, ifr;
        logic [31:0] ia;
        bit          dr, we;
        logic [3:0]  be;
        logic [31:0] da, wd;
        bit          rdy, rv;
        logic [31:0] rd;
        bit          eig, edg, eirv, edrv, emr, ewe;
        logic [3:0]  ebe;
        logic [31:0] ea, ewd;
        int          est;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: is a transaction outstanding, whose is it, and how many
    // arbitrations in a row has a waiting fetch lost.
    bit m_busy;
    bit m_who_d;
    int m_starve;
    bit x_ig, x_dg, x_irv, x_drv, x_mr, x_wind;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_who_d  = 1'b0;
        m_starve = 0;
    endtask

    task automatic model_eval();
        bit fetch_first;
        fetch_first = (m_starve >= LIM) && if_req;
        x_wind = d_req && !fetch_first;
        x_mr   = !rst && !m_busy && (if_req || d_req);
        x_dg   = x_mr && mem_ready && x_wind;
        x_ig   = x_mr && mem_ready && !x_wind;
        x_irv  = !rst && m_busy && mem_rvalid && !m_who_d;
        x_drv  = !rst && m_busy && mem_rvalid && m_who_d;
    endtask

    task automatic model_check(input string tag);
        chk({tag, " if_gnt"}, if_gnt, x_ig);
        chk({tag, " d_gnt"}, d_gnt, x_dg);
        chk({tag, " if_rvalid"}, if_rvalid, x_irv);
        chk({tag, " d_rvalid"}, d_rvalid, x_drv);
        chk({tag, " mem_req"}, mem_req, x_mr);
        chk({tag, " if_rdata"}, if_rdata, mem_rdata);
        chk({tag, " d_rdata"}, d_rdata, mem_rdata);
        chk({tag, " starve"}, dut.starve_cnt, m_starve);
        if (x_mr) begin
            chk({tag, " mem_we"}, mem_we, x_wind ? d_we : 1'b0);
            chk({tag, " mem_be"}, mem_be, x_wind ? d_be : 4'hf);
            chk({tag, " mem_addr"}, mem_addr, x_wind ? d_addr : if_addr);
            if (x_wind && d_we) chk({tag, " mem_wdata"}, mem_wdata, d_wdata);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (x_ig || x_dg) begin
                m_busy  = 1'b1;
                m_who_d = x_dg;
            end
            m_starve = (if_req && !x_ig) ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
        end else if (mem_rvalid) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic apply(input vec_t v, input bit chk_tab, input string tag);
        @(posedge clk);
        #1;
        rst        = v.rst;
        if_req     = v.ifr;
        if_addr    = v.ia;
        d_req      = v.dr;
        d_we       = v.we;
        d_be       = v.be;
        d_addr     = v.da;
        d_wdata    = v.wd;
        mem_ready  = v.rdy;
        mem_rvalid = v.rv;
        mem_rdata  = v.rd;
        if (v.rst) model_reset();
        #3;
        model_eval();
        model_check(tag);
        if (chk_tab) begin
            chk({tag, " tab if_gnt"}, if_gnt, v.eig);
            chk({tag, " tab d_gnt"}, d_gnt, v.edg);
            chk({tag, " tab if_rvalid"}, if_rvalid, v.eirv);
            chk({tag, " tab d_rvalid"}, d_rvalid, v.edrv);
            chk({tag, " tab mem_req"}, mem_req, v.emr);
            chk({tag, " tab starve"}, dut.starve_cnt, v.est);
            if (v.emr) begin
                chk({tag, " tab mem_we"}, mem_we, v.ewe);
                chk({tag, " tab mem_be"}, mem_be, v.ebe);
                chk({tag, " tab mem_addr"}, mem_addr, v.ea);
                if (v.ewe) chk({tag, " tab mem_wdata"}, mem_wdata, v.ewd);
            end
            if (v.eirv) chk({tag, " tab if_rdata"}, if_rdata, v.rd);
            if (v.edrv) chk({tag, " tab d_rdata"}, d_rdata, v.rd);
        end
        model_update();
    endtask

    vec_t tab[$];
    vec_t r;

    initial begin
        model_reset();

        // rst ifr ia dr we be da wd rdy rv rd | eig edg eirv edrv emr ewe ebe ea ewd est
        tab.push_back('{1,1,32'h100,1,0,4'hf,32'h3000,0,1,0,0, 0,0,0,0,0,0,4'h0,0,0,0});
        tab.push_back('{1,1,32'h100,1,0,4'hf,32'h3000,0,1,0,0, 0,0,0,0,0,0,4'h0,0,0,0});
        tab.push_back('{0,1,32'h100,1,0,4'hf,32'h3000,0,1,0,0, 0,1,0,0,1,0,4'hf,32'h3000,0,0});
        tab.push_back('{0,1,32'h100,0,0,4'hf,32'h3000,0,1,1,32'h11, 0,0,0,1,0,0,4'h0,0,0,1});
        tab.push_back('{0,1,32'h100,0,0,4'hf,0,0,1,0,0, 1,0,0,0,1,0,4'hf,32'h100,0,1});
        tab.push_back('{0,0,32'h100,0,0,4'hf,0,0,1,1,32'h00500093, 0,0,1,0,0,0,4'h0,0,0,0});
        tab.push_back('{0,0,0,0,0,4'hf,0,0,1,0,0, 0,0,0,0,0,0,4'h0,0,0,0});
        tab.push_back('{0,0,0,1,1,4'h3,32'h2000,32'hDEADBEEF,1,0,0, 0,1,0,0,1,1,4'h3,32'h2000,32'hDEADBEEF,0});
        tab.push_back('{0,0,0,0,0,4'hf,0,0,1,1,32'h0, 0,0,0,1,0,0,4'h0,0,0,0});
        tab.push_back('{0,1,32'h100,1,0,4'hf,32'h4000,0,0,0,0, 0,0,0,0,1,0,4'hf,32'h4000,0,0});
        tab.push_back('{0,1,32'h100,1,0,4'hf,32'h4000,0,0,0,0, 0,0,0,0,1,0,4'hf,32'h4000,0,1});
        tab.push_back('{0,1,32'h100,1,0,4'hf,32'h4000,0,0,0,0, 0,0,0,0,1,0,4'hf,32'h4000,0,2});
        tab.push_back('{0,1,32'h100,1,0,4'hf,32'h4000,0,1,0,0, 0,1,0,0,1,0,4'hf,32'h4000,0,3});
        tab.push_back('{0,1,32'h100,1,0,4'hf,32'h4000,0,1,1,32'h22, 0,0,0,1,0,0,4'h0,0,0,4});
        tab.push_back('{0,1,32'h100,1,0,4'hf,32'h4000,0,1,0,0, 1,0,0,0,1,0,4'hf,32'h100,0,4});
        tab.push_back('{0,0,0,0,0,4'hf,0,0,1,1,32'h33, 0,0,1,0,0,0,4'h0,0,0,0});
        tab.push_back('{0,0,0,0,0,4'hf,0,0,1,0,0, 0,0,0,0,0,0,4'h0,0,0,0});

        for (int i = 0; i < tab.size(); i++)
            apply(tab[i], 1'b1, $sformatf("vec%0d", i));

        // Continuous contention: data takes four arbitrations, fetch the fifth.
        for (int k = 0; k <= LIM; k++) begin
            r = '{0,1,32'h100,1,0,4'hf,32'h5000,0,1,0,0, 0,0,0,0,1,0,4'hf,0,0,0};
            r.eig = (k == LIM);
            r.edg = (k < LIM);
            r.ea  = (k < LIM) ? 32'h5000 : 32'h100;
            r.est = k;
            apply(r, 1'b1, $sformatf("cont%0d arb", k));
            r = '{0,1,32'h100,1,0,4'hf,32'h5000,0,1,1,32'h77, 0,0,0,0,0,0,4'h0,0,0,0};
            r.ifr  = (k < LIM);
            r.dr   = (k < LIM);
            r.eirv = (k == LIM);
            r.edrv = (k < LIM);
            r.est  = (k < LIM) ? k + 1 : 0;
            apply(r, 1'b1, $sformatf("cont%0d rsp", k));
        end
        apply('{0,0,0,0,0,4'hf,0,0,1,0,0, 0,0,0,0,0,0,4'h0,0,0,0}, 1'b1, "cont idle");

        // Reset while a fetch is in flight; the late response must be dropped.
        apply('{0,1,32'h200,0,0,4'hf,0,0,1,0,0, 1,0,0,0,1,0,4'hf,32'h200,0,0}, 1'b1, "rstmid gnt");
        apply('{1,0,0,0,0,4'hf,0,0,1,0,0, 0,0,0,0,0,0,4'h0,0,0,0}, 1'b1, "rstmid rst");
        apply('{0,0,0,0,0,4'hf,0,0,1,1,32'h55, 0,0,0,0,0,0,4'h0,0,0,0}, 1'b1, "rstmid late");
        apply('{0,0,0,1,0,4'hf,32'h6000,0,1,0,0, 0,1,0,0,1,0,4'hf,32'h6000,0,0}, 1'b1, "rstmid next");
        apply('{0,0,0,0,0,4'hf,0,0,1,1,32'h66, 0,0,0,1,0,0,4'h0,0,0,0}, 1'b1, "rstmid rsp");

        // Randomized traffic; requests are held until granted, occasionally withdrawn.
        r = '{0,0,0,0,0,4'hf,0,0,1,0,0, 0,0,0,0,0,0,4'h0,0,0,0};
        for (int n = 0; n < 3000; n++) begin
            apply(r, 1'b0, $sformatf("rnd%0d", n));
            if (!r.ifr || x_ig || r.rst) begin
                r.ifr = ($urandom_range(0, 2) != 0);
                r.ia  = $urandom & 32'hffff_fffc;
            end else if ($urandom_range(0, 19) == 0) begin
                r.ifr = 1'b0;
            end
            if (!r.dr || x_dg || r.rst) begin
                r.dr = ($urandom_range(0, 2) != 0);
                r.we = $urandom_range(0, 1);
                r.be = $urandom_range(0, 15);
                r.da = $urandom;
                r.wd = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                r.dr = 1'b0;
            end
            r.rdy = ($urandom_range(0, 3) != 0);
            r.rv  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            r.rd  = $urandom;
            r.rst = ($urandom_range(0, 149) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
